// File: rtl/bf_norm_round_pipe.sv
// ---------------------------------------------------------------------------
// bf_norm_round_pipe
//
// Two-stage normalise-and-round stage for the variable-precision BFloat16
// multiplier datapath. Consumes the raw double-width significand product and
// the signed biased exponent sum, and produces a normalised, rounded,
// range-checked sign/exponent/fraction result with overflow/underflow flags.
//
//   Stage 1: 1-bit normalise (product in [1,4)), extract fraction, guard and
//            sticky, detect a zero product.
//   Stage 2: RNE or truncate rounding, carry renormalisation, saturate to
//            infinity / flush to zero.
//
// Parameters
//   MW : stored fraction bits (hidden bit excluded); product width 2*MW+2
//   EW : stored exponent bits; internal exponent is signed, EW+2 bits
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   input beat handshake
//   in_sign             product sign
//   in_exp   [EW+1:0]   signed two's-complement biased exponent sum
//   in_mant  [2MW+1:0]  unsigned product of two 1.MW significands
//   rnd_mode            0 = round-to-nearest-even, 1 = truncate (per beat)
//   out_valid/out_ready result handshake
//   out_sign            result sign (always passed through)
//   out_exp  [EW-1:0]   result biased exponent
//   out_frac [MW-1:0]   result fraction
//   out_ovf             overflow, result saturated to infinity
//   out_udf             underflow, result flushed to zero
// ---------------------------------------------------------------------------
module bf_norm_round_pipe #(
    parameter int unsigned MW = 7,
    parameter int unsigned EW = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_sign,
    input  logic [EW+1:0]       in_exp,
    input  logic [2*MW+1:0]     in_mant,
    input  logic                rnd_mode,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_sign,
    output logic [EW-1:0]       out_exp,
    output logic [MW-1:0]       out_frac,
    output logic                out_ovf,
    output logic                out_udf
);

    localparam int unsigned PW = 2 * MW + 2;
    localparam int unsigned XW = EW + 2;

    // Largest biased exponent value; anything at or above it is infinity.
    localparam logic signed [XW-1:0] EMAX = XW'((1 << EW) - 1);

    // -----------------------------------------------------------------------
    // Handshake
    // -----------------------------------------------------------------------
    logic s1_valid_q;
    logic out_valid_q;
    logic s2_ready;
    logic in_fire;
    logic s1_advance;

    assign s2_ready   = !out_valid_q || out_ready;
    assign in_ready   = !s1_valid_q || s2_ready;
    assign in_fire    = in_valid && in_ready;
    assign s1_advance = s1_valid_q && s2_ready;

    // -----------------------------------------------------------------------
    // Stage 1: normalise
    // -----------------------------------------------------------------------
    logic [PW-1:0]        mant_aligned;
    logic signed [XW-1:0] s1_exp_d;
    logic [MW-1:0]        s1_frac_d;
    logic                 s1_guard_d;
    logic                 s1_sticky_d;
    logic                 s1_zero_d;

    // Aligning the product so its leading one sits at PW-1 lets a single set
    // of bit positions serve both cases; the zero shifted in below the guard
    // does not disturb the sticky OR.
    always_comb begin
        mant_aligned = in_mant;
        s1_exp_d     = $signed(in_exp);
        if (in_mant[PW-1]) begin
            s1_exp_d = $signed(in_exp) + XW'(1);
        end else begin
            mant_aligned = {in_mant[PW-2:0], 1'b0};
        end
        s1_frac_d   = mant_aligned[PW-2 -: MW];
        s1_guard_d  = mant_aligned[PW-2-MW];
        s1_sticky_d = |mant_aligned[PW-3-MW:0];
        s1_zero_d   = (in_mant == '0);
    end

    logic                 s1_sign_q;
    logic signed [XW-1:0] s1_exp_q;
    logic [MW-1:0]        s1_frac_q;
    logic                 s1_guard_q;
    logic                 s1_sticky_q;
    logic                 s1_zero_q;
    logic                 s1_rnd_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_exp_q    <= '0;
            s1_frac_q   <= '0;
            s1_guard_q  <= 1'b0;
            s1_sticky_q <= 1'b0;
            s1_zero_q   <= 1'b0;
            s1_rnd_q    <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_valid_q <= in_valid;
            end
            if (in_fire) begin
                s1_sign_q   <= in_sign;
                s1_exp_q    <= s1_exp_d;
                s1_frac_q   <= s1_frac_d;
                s1_guard_q  <= s1_guard_d;
                s1_sticky_q <= s1_sticky_d;
                s1_zero_q   <= s1_zero_d;
                s1_rnd_q    <= rnd_mode;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stage 2: round and range check
    // -----------------------------------------------------------------------
    logic                 rnd_inc;
    logic [MW:0]          frac_sum;
    logic signed [XW-1:0] e_rnd;
    logic                 out_sign_d;
    logic [EW-1:0]        out_exp_d;
    logic [MW-1:0]        out_frac_d;
    logic                 out_ovf_d;
    logic                 out_udf_d;

    // A carry out of the fraction means it was all ones; the remaining MW
    // bits are then already zero, so only the exponent needs bumping.
    always_comb begin
        rnd_inc    = !s1_rnd_q && s1_guard_q && (s1_sticky_q || s1_frac_q[0]);
        frac_sum   = {1'b0, s1_frac_q} + (MW+1)'(rnd_inc);
        e_rnd      = s1_exp_q + XW'(frac_sum[MW]);

        out_sign_d = s1_sign_q;
        out_exp_d  = '0;
        out_frac_d = '0;
        out_ovf_d  = 1'b0;
        out_udf_d  = 1'b0;

        if (s1_zero_q) begin
            // zero product outranks any exponent range condition
            out_exp_d = '0;
        end else if (e_rnd >= EMAX) begin
            out_exp_d = '1;
            out_ovf_d = 1'b1;
        end else if (e_rnd[XW-1] || (e_rnd == '0)) begin
            out_udf_d = 1'b1;
        end else begin
            out_exp_d  = e_rnd[EW-1:0];
            out_frac_d = frac_sum[MW-1:0];
        end
    end

    logic          out_sign_q;
    logic [EW-1:0] out_exp_q;
    logic [MW-1:0] out_frac_q;
    logic          out_ovf_q;
    logic          out_udf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_sign_q  <= 1'b0;
            out_exp_q   <= '0;
            out_frac_q  <= '0;
            out_ovf_q   <= 1'b0;
            out_udf_q   <= 1'b0;
        end else begin
            if (s2_ready) begin
                out_valid_q <= s1_valid_q;
            end
            if (s1_advance) begin
                out_sign_q <= out_sign_d;
                out_exp_q  <= out_exp_d;
                out_frac_q <= out_frac_d;
                out_ovf_q  <= out_ovf_d;
                out_udf_q  <= out_udf_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_sign  = out_sign_q;
    assign out_exp   = out_exp_q;
    assign out_frac  = out_frac_q;
    assign out_ovf   = out_ovf_q;
    assign out_udf   = out_udf_q;

endmodule

// File: tb/tb_bf_norm_round_pipe.sv
// ---------------------------------------------------------------------------
// tb_bf_norm_round_pipe
//
// Directed table of single beats with hand-computed results, followed by a
// backpressure stream and a mid-stream reset sequence.
// ---------------------------------------------------------------------------
module tb_bf_norm_round_pipe;

    localparam int unsigned MW = 7;
    localparam int unsigned EW = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [9:0]  in_exp = '0;
    logic [15:0] in_mant = '0;
    logic        rnd_mode = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_sign;
    logic [7:0]  out_exp;
    logic [6:0]  out_frac;
    logic        out_ovf;
    logic        out_udf;

    bf_norm_round_pipe #(.MW(MW), .EW(EW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_mant   (in_mant),
        .rnd_mode  (rnd_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sign  (out_sign),
        .out_exp   (out_exp),
        .out_frac  (out_frac),
        .out_ovf   (out_ovf),
        .out_udf   (out_udf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sign;
        logic [9:0]  exp;
        logic [15:0] mant;
        logic        rnd;
        logic        e_sign;
        logic [7:0]  e_exp;
        logic [6:0]  e_frac;
        logic        e_ovf;
        logic        e_udf;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_result(input string tag, input vec_t v);
        check({tag, ".sign"}, 32'(out_sign), 32'(v.e_sign));
        check({tag, ".exp"},  32'(out_exp),  32'(v.e_exp));
        check({tag, ".frac"}, 32'(out_frac), 32'(v.e_frac));
        check({tag, ".ovf"},  32'(out_ovf),  32'(v.e_ovf));
        check({tag, ".udf"},  32'(out_udf),  32'(v.e_udf));
    endtask

    task automatic drive(input vec_t v);
        in_valid = 1'b1;
        in_sign  = v.sign;
        in_exp   = v.exp;
        in_mant  = v.mant;
        rnd_mode = v.rnd;
    endtask

    // One isolated beat: checks acceptance, 2-cycle latency and the result.
    task automatic send_one(input string tag, input vec_t v);
        int lat;
        @(negedge clk);
        out_ready = 1'b1;
        drive(v);
        #1;
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        check({tag, ".latency"}, 32'(lat), 32'd2);
        check_result(tag, v);
    endtask

    initial begin
        vec_t v;
        vec_t snap;
        int   idx;
        int   rcv;
        int   cyc;
        logic saw_stall_in;
        logic have_snap;

        //           sign  in_exp   in_mant   rnd   sign  exp     frac   ovf   udf
        vecs[0]  = '{1'b1, 10'd128, 16'h9000, 1'b0, 1'b1, 8'd129, 7'h10, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 10'd100, 16'h40C0, 1'b0, 1'b0, 8'd100, 7'h02, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 10'd100, 16'h40C0, 1'b1, 1'b0, 8'd100, 7'h01, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 10'd100, 16'h4040, 1'b0, 1'b0, 8'd100, 7'h00, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 10'd100, 16'h7FC0, 1'b0, 1'b0, 8'd101, 7'h00, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 10'd254, 16'h8000, 1'b0, 1'b0, 8'hFF,  7'h00, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 10'd0,   16'h4000, 1'b0, 1'b1, 8'h00,  7'h00, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 10'h3FB, 16'h4000, 1'b0, 1'b0, 8'h00,  7'h00, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 10'd200, 16'h0000, 1'b0, 1'b1, 8'h00,  7'h00, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 10'd300, 16'h0000, 1'b0, 1'b0, 8'h00,  7'h00, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 10'd253, 16'h8000, 1'b0, 1'b0, 8'd254, 7'h00, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 10'd254, 16'h7FC0, 1'b0, 1'b1, 8'hFF,  7'h00, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 10'd0,   16'h8000, 1'b0, 1'b0, 8'd1,   7'h00, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 10'd100, 16'h4041, 1'b0, 1'b0, 8'd100, 7'h01, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 10'd100, 16'h403F, 1'b0, 1'b0, 8'd100, 7'h00, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 10'd10,  16'hC0FF, 1'b0, 1'b1, 8'd11,  7'h41, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 10'd100, 16'h7FC0, 1'b1, 1'b0, 8'd100, 7'h7F, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 10'h3FF, 16'h8000, 1'b0, 1'b0, 8'h00,  7'h00, 1'b0, 1'b1};

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.out_exp",   32'(out_exp),   32'd0);
        check("rst.out_frac",  32'(out_frac),  32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst.in_ready", 32'(in_ready), 32'd1);

        // ---------------- directed table ----------------
        for (int i = 0; i < NV; i++) begin
            send_one($sformatf("vec%0d", i), vecs[i]);
        end
        @(negedge clk);
        check("idle.out_valid", 32'(out_valid), 32'd0);

        // ---------------- backpressure stream ----------------
        idx = 0;
        rcv = 0;
        cyc = 0;
        saw_stall_in = 1'b0;
        have_snap = 1'b0;
        while (rcv < 5 && cyc < 40) begin
            out_ready = !(cyc >= 3 && cyc <= 6);
            if (idx < 5) drive(vecs[idx]);
            else in_valid = 1'b0;
            #1;
            if (out_valid && out_ready) begin
                check_result($sformatf("bp.out%0d", rcv), vecs[rcv]);
                rcv++;
                have_snap = 1'b0;
            end else if (out_valid && !out_ready) begin
                if (have_snap) begin
                    check("bp.hold.exp",  32'(out_exp),  32'(snap.e_exp));
                    check("bp.hold.frac", 32'(out_frac), 32'(snap.e_frac));
                    check("bp.hold.sign", 32'(out_sign), 32'(snap.e_sign));
                end else begin
                    snap.e_exp  = out_exp;
                    snap.e_frac = out_frac;
                    snap.e_sign = out_sign;
                    have_snap = 1'b1;
                end
            end
            if (in_valid && !in_ready && !saw_stall_in) begin
                saw_stall_in = 1'b1;
                check("bp.buffered", 32'(idx - rcv), 32'd2);
            end
            if (in_valid && in_ready) idx++;
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("bp.received", 32'(rcv), 32'd5);
        check("bp.in_ready_fell", 32'(saw_stall_in), 32'd1);
        repeat (3) @(negedge clk);
        check("bp.no_extra", 32'(out_valid), 32'd0);

        // ---------------- reset with both stages full ----------------
        @(negedge clk);
        out_ready = 1'b0;
        drive(vecs[5]);
        @(negedge clk);
        drive(vecs[0]);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("mid.full.out_valid", 32'(out_valid), 32'd1);
        check("mid.full.in_ready",  32'(in_ready),  32'd0);
        rst_n = 1'b0;
        #1;
        check("mid.rst.out_valid", 32'(out_valid), 32'd0);
        check("mid.rst.out_exp",   32'(out_exp),   32'd0);
        check("mid.rst.out_ovf",   32'(out_ovf),   32'd0);
        check("mid.rst.out_sign",  32'(out_sign),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        check("mid.post.in_ready", 32'(in_ready), 32'd1);
        send_one("mid.after", vecs[15]);
        repeat (3) @(negedge clk);
        check("mid.drain.out_valid", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bf_norm_round_pipe.md
Name: bf_norm_round_pipe

Overview:
- Parametrised, pipelined normalise-and-round stage for the variable-precision approximate BFloat16 multiplier datapath.
- Takes the raw double-width significand product and the biased exponent sum. Produces a normalised, rounded, range-checked sign/exponent/fraction result with overflow and underflow flags.
- Extends the earlier combinational 1-bit normaliser with:
  - selectable RNE or truncate rounding
  - carry-out renormalisation after rounding
  - saturation to infinity and flush to zero
  - zero-product detection
  - a 2-stage valid/ready pipeline with backpressure

Parameters:
MW, 7, stored fraction bits (hidden bit excluded); product width PW = 2*MW+2
EW, 8, stored exponent bits; internal exponent is signed, EW+2 bits

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input beat valid
in_ready  output  1  block can accept a beat this cycle
in_sign  input  1  product sign
in_exp  input  EW+2  signed two's-complement biased exponent sum (bias already removed once)
in_mant  input  PW  unsigned product of two 1.MW significands
rnd_mode  input  1  0 = round-to-nearest-even, 1 = truncate; sampled with the beat
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_sign  output  1  result sign
out_exp  output  EW  result biased exponent
out_frac  output  MW  result fraction
out_ovf  output  1  overflow, result saturated to infinity
out_udf  output  1  underflow, result flushed to zero

Behaviour:
- Reset (async, rst_n=0): both stage valid bits clear; all out_* registers = 0; in_ready = 1 after reset.
- Handshake:
  - beat transfers on in_valid & in_ready; result transfers on out_valid & out_ready.
  - s2_ready = !s2_valid | out_ready; in_ready = !s1_valid | s2_ready.
  - Throughput is 1 beat/cycle. Latency is 2 cycles from accept to out_valid when there is no stall.
  - Stalled stages hold contents unchanged.
  - out_* must not change while out_valid & !out_ready.
- Stage 1, normalise:
  - If in_mant[PW-1]=1: exponent e = in_exp+1; fraction = in_mant[PW-2 -: MW]; guard = in_mant[PW-2-MW]; sticky = OR of remaining lower bits.
  - Else: e = in_exp; fraction = in_mant[PW-3 -: MW]; guard = in_mant[PW-3-MW]; sticky = OR of bits below the guard.
  - zero flag = (in_mant == 0).
  - Register sign, e, fraction, guard, sticky, zero, rnd_mode.
- Stage 2, round and range:
  - RNE: increment = guard & (sticky | frac[0]). Truncate: increment = 0.
  - If the fraction is all ones and increment = 1: frac = 0, e = e+1 (carry renormalise).
  - Zero flag set: exp = 0, frac = 0, ovf = 0, udf = 0 (zero has priority).
  - Else if e >= 2^EW-1 (signed compare): exp = all ones, frac = 0, ovf = 1.
  - Else if e <= 0: exp = 0, frac = 0, udf = 1.
  - Else: exp = e[EW-1:0], frac = rounded fraction.
  - Sign always passes through unchanged.
- Flags are per-beat and valid only with out_valid.
- Reset mid-stream discards in-flight beats; no partial output.

Test Plan:
Values below use the defaults MW=7, EW=8, RNE mode unless stated.
- Overflow-normalise, no stall: in_mant=0x9000, in_exp=128, sign=1 -> 2 cycles later out_exp=129, out_frac=0x10, sign=1, flags 0.
- RNE tie, odd LSB: in_mant=0x40C0, in_exp=100 -> out_frac=0x02, exp=100. Same beat with rnd_mode=1 -> out_frac=0x01. Tie with even LSB, in_mant=0x4040 -> out_frac=0x00.
- Rounding carry: in_mant=0x7FC0, in_exp=100 -> out_exp=101, out_frac=0x00.
- Range cases:
  - in_mant=0x8000, in_exp=254 -> out_exp=0xFF, frac=0, ovf=1.
  - in_mant=0x4000, in_exp=0 -> exp=0, frac=0, udf=1.
  - in_exp=-5 -> udf=1.
  - in_mant=0 at any in_exp -> all zero, no flags.
- Backpressure: stream 5 back-to-back beats with out_ready held low for cycles 3-6 -> in_ready falls after 2 beats are buffered; all 5 results emerge in order, no loss or duplication, and out_* remain stable while stalled.
- Reset mid-operation: assert rst_n=0 with both stages full -> out_valid=0 and outputs=0 immediately; after release in_ready=1 and the next beat completes normally.
